vend_controller: RTL and testbench

- Multi-product vending sequencer: accumulates coin credit, arbitrates product selection against per-product price and stock, issues one-cycle vend strobes, then pays out change one coin per cycle.
- Sits above the coin-acceptor front end; drives the dispenser and change hopper.
- Coin encoding matches the existing coin path: 2'b01 = 5 units, 2'b10 = 10 units.

---
 rtl/vend_controller.sv | 198 +++++++++++++++++++
 tb/tb_vend_controller.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// Multi-product vending sequencer: coin credit, price/stock-checked selection,
// one-cycle vend strobe, then one change coin per cycle until credit is zero.
module vend_controller #(
    parameter int unsigned NUM_PROD   = 4,
    parameter int unsigned CREDIT_W   = 6,
    parameter int unsigned MAX_CREDIT = 40,
    parameter int unsigned PRICE0     = 15,
    parameter int unsigned PRICE1     = 20,
    parameter int unsigned PRICE2     = 25,
    parameter int unsigned PRICE3     = 30,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned STOCK_INIT = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic                sel_valid,
    input  logic [1:0]          sel_id,
    input  logic                cancel,
    input  logic                refill,
    output logic                product_valid,
    output logic [1:0]          product_id,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    output logic                coin_reject,
    output logic                sel_err,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit,
    output logic [NUM_PROD-1:0] sold_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_REFUND = 2'd3
    } state_e;

    localparam int unsigned SUM_W   = CREDIT_W + 1;
    localparam logic [1:0]  COIN_5  = 2'b01;
    localparam logic [1:0]  COIN_10 = 2'b10;

    function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] id);
        case (id)
            2'd0:    return CREDIT_W'(PRICE0);
            2'd1:    return CREDIT_W'(PRICE1);
            2'd2:    return CREDIT_W'(PRICE2);
            default: return CREDIT_W'(PRICE3);
        endcase
    endfunction

    state_e                            state_q, state_d;
    logic [CREDIT_W-1:0]               credit_q, credit_d;
    logic [NUM_PROD-1:0][STOCK_W-1:0]  stock_q, stock_d;
    logic [1:0]                        sel_q, sel_d;
    logic                              product_valid_q, product_valid_d;
    logic [1:0]                        product_id_q, product_id_d;
    logic                              change_valid_q, change_valid_d;
    logic [1:0]                        change_coin_q, change_coin_d;
    logic                              coin_reject_q, coin_reject_d;
    logic                              sel_err_q, sel_err_d;
    logic                              busy_q, busy_d;

    logic                coin_ok;
    logic [CREDIT_W-1:0] coin_amt;
    logic [SUM_W-1:0]    credit_sum;
    logic [CREDIT_W-1:0] sel_price;
    logic [CREDIT_W-1:0] vend_price;
    logic [CREDIT_W-1:0] change_amt;
    logic                sel_ok;

    // Decoded coin value and purchase eligibility for the current request
    always_comb begin
        coin_ok    = (coin == COIN_5) || (coin == COIN_10);
        coin_amt   = (coin == COIN_10) ? CREDIT_W'(10) :
                     (coin == COIN_5)  ? CREDIT_W'(5)  : '0;
        credit_sum = SUM_W'(credit_q) + SUM_W'(coin_amt);
        sel_price  = price_of(sel_id);
        vend_price = price_of(sel_q);
        sel_ok     = (stock_q[sel_id] != '0) && (credit_q >= sel_price);
        change_amt = (credit_q >= CREDIT_W'(10)) ? CREDIT_W'(10) : CREDIT_W'(5);
    end

    // Next-state, datapath and registered-output staging
    always_comb begin
        state_d         = state_q;
        credit_d        = credit_q;
        stock_d         = stock_q;
        sel_d           = sel_q;
        coin_reject_d   = 1'b0;
        sel_err_d       = 1'b0;
        product_valid_d = 1'b0;
        product_id_d    = '0;
        change_valid_d  = 1'b0;
        change_coin_d   = '0;
        busy_d          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (coin_ok) begin
                    credit_d = coin_amt;
                    state_d  = ST_CREDIT;
                end
                if (refill) begin
                    stock_d = {NUM_PROD{STOCK_W'(STOCK_INIT)}};
                end
                sel_err_d = sel_valid;
            end
            ST_CREDIT: begin
                if (cancel) begin
                    state_d       = ST_REFUND;
                    coin_reject_d = coin_ok;
                end else if (sel_valid && sel_ok) begin
                    sel_d         = sel_id;
                    state_d       = ST_VEND;
                    coin_reject_d = coin_ok;
                end else begin
                    sel_err_d = sel_valid;
                    if (coin_ok) begin
                        if (credit_sum <= SUM_W'(MAX_CREDIT)) begin
                            credit_d = CREDIT_W'(credit_sum);
                        end else begin
                            coin_reject_d = 1'b1;
                        end
                    end
                end
            end
            ST_VEND: begin
                if (stock_q[sel_q] != '0) begin
                    stock_d[sel_q] = stock_q[sel_q] - STOCK_W'(1);
                end
                credit_d      = (credit_q >= vend_price) ? credit_q - vend_price : '0;
                state_d       = (credit_d != '0) ? ST_REFUND : ST_IDLE;
                coin_reject_d = coin_ok;
                sel_err_d     = sel_valid;
            end
            default: begin
                credit_d      = (credit_q >= change_amt) ? credit_q - change_amt : '0;
                state_d       = (credit_d == '0) ? ST_IDLE : ST_REFUND;
                coin_reject_d = coin_ok;
                sel_err_d     = sel_valid;
            end
        endcase

        // Outputs describe the cycle about to start, so they follow state_d/credit_d
        busy_d          = (state_d == ST_VEND) || (state_d == ST_REFUND);
        product_valid_d = (state_d == ST_VEND);
        product_id_d    = product_valid_d ? sel_d : '0;
        change_valid_d  = (state_d == ST_REFUND);
        change_coin_d   = !change_valid_d            ? 2'b00   :
                          (credit_d >= CREDIT_W'(10)) ? COIN_10 : COIN_5;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            credit_q        <= '0;
            stock_q         <= {NUM_PROD{STOCK_W'(STOCK_INIT)}};
            sel_q           <= '0;
            product_valid_q <= 1'b0;
            product_id_q    <= '0;
            change_valid_q  <= 1'b0;
            change_coin_q   <= '0;
            coin_reject_q   <= 1'b0;
            sel_err_q       <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            credit_q        <= credit_d;
            stock_q         <= stock_d;
            sel_q           <= sel_d;
            product_valid_q <= product_valid_d;
            product_id_q    <= product_id_d;
            change_valid_q  <= change_valid_d;
            change_coin_q   <= change_coin_d;
            coin_reject_q   <= coin_reject_d;
            sel_err_q       <= sel_err_d;
            busy_q          <= busy_d;
        end
    end

    // Sold-out flags track the stock registers directly
    always_comb begin
        for (int i = 0; i < int'(NUM_PROD); i++) begin
            sold_out[i] = (stock_q[i] == '0);
        end
    end

    assign product_valid = product_valid_q;
    assign product_id    = product_id_q;
    assign change_valid  = change_valid_q;
    assign change_coin   = change_coin_q;
    assign coin_reject   = coin_reject_q;
    assign sel_err       = sel_err_q;
    assign busy          = busy_q;
    assign credit        = credit_q;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: a transaction-level model plans each
// vend/refund as a list of output cycles and is compared every cycle.
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] coin;
    logic       sel_valid;
    logic [1:0] sel_id;
    logic       cancel;
    logic       refill;
    logic       product_valid;
    logic [1:0] product_id;
    logic       change_valid;
    logic [1:0] change_coin;
    logic       coin_reject;
    logic       sel_err;
    logic       busy;
    logic [5:0] credit;
    logic [3:0] sold_out;

    vend_controller dut (
        .clk           (clk),
        .rst           (rst),
        .coin          (coin),
        .sel_valid     (sel_valid),
        .sel_id        (sel_id),
        .cancel        (cancel),
        .refill        (refill),
        .product_valid (product_valid),
        .product_id    (product_id),
        .change_valid  (change_valid),
        .change_coin   (change_coin),
        .coin_reject   (coin_reject),
        .sel_err       (sel_err),
        .busy          (busy),
        .credit        (credit),
        .sold_out      (sold_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One planned busy cycle: either a vend strobe or a change coin
    typedef struct {
        bit pv;
        int pid;
        bit cv;
        int amt;
        int cr;
    } slot_t;

    slot_t plan[$];
    int    m_credit;
    int    m_stock[4];
    bit    m_rej;
    bit    m_err;
    int    price[4] = '{15, 20, 25, 30};

    function automatic int coin_value(input logic [1:0] c);
        if (c == 2'b01) return 5;
        if (c == 2'b10) return 10;
        return 0;
    endfunction

    task automatic plan_change(input int amount);
        int rem;
        int c;
        slot_t s;
        rem = amount;
        while (rem > 0) begin
            c = (rem >= 10) ? 10 : 5;
            s = '{pv: 1'b0, pid: 0, cv: 1'b1, amt: c, cr: rem};
            plan.push_back(s);
            rem -= c;
        end
    endtask

    always @(posedge clk or negedge rst) begin
        int    v;
        slot_t s;
        if (!rst) begin
            plan.delete();
            m_credit = 0;
            for (int i = 0; i < 4; i++) m_stock[i] = 5;
            m_rej = 1'b0;
            m_err = 1'b0;
        end else begin
            v     = coin_value(coin);
            m_rej = 1'b0;
            m_err = 1'b0;
            if (plan.size() > 0) begin
                s = plan.pop_front();
                if (s.pv) m_stock[s.pid] = m_stock[s.pid] - 1;
                m_rej = (v > 0);
                m_err = sel_valid;
            end else if (m_credit == 0) begin
                if (v > 0) m_credit = v;
                if (refill) for (int i = 0; i < 4; i++) m_stock[i] = 5;
                m_err = sel_valid;
            end else if (cancel) begin
                plan_change(m_credit);
                m_credit = 0;
                m_rej = (v > 0);
            end else if (sel_valid && m_stock[sel_id] > 0 && m_credit >= price[sel_id]) begin
                s = '{pv: 1'b1, pid: int'(sel_id), cv: 1'b0, amt: 0, cr: m_credit};
                plan.push_back(s);
                plan_change(m_credit - price[sel_id]);
                m_credit = 0;
                m_rej = (v > 0);
            end else begin
                m_err = sel_valid;
                if (v > 0) begin
                    if (m_credit + v <= 40) m_credit += v;
                    else m_rej = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        logic       e_pv, e_cv, e_busy;
        logic [1:0] e_pid, e_coin;
        logic [5:0] e_cr;
        logic [3:0] e_so;
        if (chk_en) begin
            if (plan.size() > 0) begin
                e_pv   = plan[0].pv;
                e_pid  = plan[0].pv ? 2'(plan[0].pid) : 2'b00;
                e_cv   = plan[0].cv;
                e_coin = !plan[0].cv ? 2'b00 : (plan[0].amt == 10) ? 2'b10 : 2'b01;
                e_cr   = 6'(plan[0].cr);
                e_busy = 1'b1;
            end else begin
                e_pv   = 1'b0;
                e_pid  = 2'b00;
                e_cv   = 1'b0;
                e_coin = 2'b00;
                e_cr   = 6'(m_credit);
                e_busy = 1'b0;
            end
            for (int i = 0; i < 4; i++) e_so[i] = (m_stock[i] == 0);
            check("product_valid", 8'(product_valid), 8'(e_pv));
            check("product_id",    8'(product_id),    8'(e_pid));
            check("change_valid",  8'(change_valid),  8'(e_cv));
            check("change_coin",   8'(change_coin),   8'(e_coin));
            check("coin_reject",   8'(coin_reject),   8'(m_rej));
            check("sel_err",       8'(sel_err),       8'(m_err));
            check("busy",          8'(busy),          8'(e_busy));
            check("credit",        8'(credit),        8'(e_cr));
            check("sold_out",      8'(sold_out),      8'(e_so));
        end
    end

    task automatic cyc(input logic [1:0] c, input logic sv, input logic [1:0] sid,
                       input logic cn, input logic rf);
        coin      = c;
        sel_valid = sv;
        sel_id    = sid;
        cancel    = cn;
        refill    = rf;
        @(posedge clk);
        @(negedge clk);
        coin      = 2'b00;
        sel_valid = 1'b0;
        sel_id    = 2'b00;
        cancel    = 1'b0;
        refill    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_chg;
        int n_busy;
        rst       = 1'b0;
        coin      = 2'b00;
        sel_valid = 1'b0;
        sel_id    = 2'b00;
        cancel    = 1'b0;
        refill    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_credit",   8'(credit),       8'd0);
        check("rst_busy",     8'(busy),         8'd0);
        check("rst_sold_out", 8'(sold_out),     8'd0);
        check("rst_pv",       8'(product_valid), 8'd0);
        rst    = 1'b1;
        chk_en = 1'b1;

        // 1: exact payment, no change
        cyc(2'b10, 1'b0, 2'd0, 1'b0, 1'b0);
        check("t1_credit10", 8'(credit), 8'd10);
        cyc(2'b01, 1'b0, 2'd0, 1'b0, 1'b0);
        check("t1_credit15", 8'(credit), 8'd15);
        cyc(2'b00, 1'b1, 2'd0, 1'b0, 1'b0);
        check("t1_pv", 8'(product_valid), 8'd1);
        check("t1_pid", 8'(product_id), 8'd0);
        idle(1);
        check("t1_idle_credit", 8'(credit), 8'd0);
        check("t1_no_change", 8'(change_valid), 8'd0);

        // 2: overpay by 5, one change coin
        cyc(2'b10, 1'b0, 2'd0, 1'b0, 1'b0);
        cyc(2'b10, 1'b0, 2'd0, 1'b0, 1'b0);
        check("t2_credit20", 8'(credit), 8'd20);
        cyc(2'b00, 1'b1, 2'd0, 1'b0, 1'b0);
        idle(1);
        check("t2_cv", 8'(change_valid), 8'd1);
        check("t2_coin5", 8'(change_coin), 8'd1);
        idle(1);
        check("t2_done", 8'(busy), 8'd0);

        // 3: credit ceiling, then full refund of 40
        repeat (4) cyc(2'b10, 1'b0, 2'd0, 1'b0, 1'b0);
        check("t3_credit40", 8'(credit), 8'd40);
        cyc(2'b01, 1'b0, 2'd0, 1'b0, 1'b0);
        check("t3_reject", 8'(coin_reject), 8'd1);
        check("t3_hold40", 8'(credit), 8'd40);
        cyc(2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
        n_chg  = 0;
        n_busy = 0;
        for (int k = 0; k < 6; k++) begin
            if (change_valid && change_coin == 2'b10) n_chg++;
            if (busy) n_busy++;
            idle(1);
        end
        check("t3_ten_coins", 8'(n_chg), 8'd4);
        check("t3_busy_cycles", 8'(n_busy), 8'd4);

        // 4: refused selections, coin still credited alongside a refusal
        cyc(2'b10, 1'b0, 2'd0, 1'b0, 1'b0);
        cyc(2'b00, 1'b1, 2'd0, 1'b0, 1'b0);
        check("t4_err", 8'(sel_err), 8'd1);
        check("t4_credit10", 8'(credit), 8'd10);
        cyc(2'b01, 1'b1, 2'd1, 1'b0, 1'b0);
        check("t4_err2", 8'(sel_err), 8'd1);
        check("t4_credit15", 8'(credit), 8'd15);
        cyc(2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
        idle(3);

        // 5: exhaust product 3, refused while sold out, refill clears flags
        for (int k = 0; k < 5; k++) begin
            repeat (3) cyc(2'b10, 1'b0, 2'd0, 1'b0, 1'b0);
            cyc(2'b00, 1'b1, 2'd3, 1'b0, 1'b0);
            idle(1);
        end
        check("t5_sold_out", 8'(sold_out), 8'b0000_1000);
        repeat (3) cyc(2'b10, 1'b0, 2'd0, 1'b0, 1'b0);
        cyc(2'b00, 1'b1, 2'd3, 1'b0, 1'b0);
        check("t5_err", 8'(sel_err), 8'd1);
        check("t5_credit30", 8'(credit), 8'd30);
        cyc(2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
        idle(4);
        cyc(2'b00, 1'b0, 2'd0, 1'b0, 1'b1);
        check("t5_refilled", 8'(sold_out), 8'd0);

        // 6: asynchronous reset in the middle of a refund
        repeat (4) cyc(2'b10, 1'b0, 2'd0, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
        idle(1);
        check("t6_mid_refund", 8'(credit), 8'd30);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_cv",     8'(change_valid), 8'd0);
        check("t6_rst_coin",   8'(change_coin),  8'd0);
        check("t6_rst_busy",   8'(busy),         8'd0);
        check("t6_rst_credit", 8'(credit),       8'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(3);
        check("t6_post_credit", 8'(credit), 8'd0);
        check("t6_post_cv",     8'(change_valid), 8'd0);
        check("t6_post_so",     8'(sold_out), 8'd0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
